// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/done handshake and operand/result bundle
interface serial_sub_if
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, overflow
   );

endinterface

// File: rtl/fullsub_gate.sv
// rtl/fullsub_gate.sv - gate-level one-bit full subtractor cell
module fullsub_gate (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic x_xor_y;
   logic x_n;
   logic t_xy;
   logic t_xb;
   logic t_yb;
   logic t_or;

   // difference bit: x ^ y ^ bin
   xor g_x0 (x_xor_y, x, y);
   xor g_x1 (d, x_xor_y, bin);

   // borrow out: (~x & y) | (~x & bin) | (y & bin)
   not g_n0 (x_n, x);
   and g_a0 (t_xy, x_n, y);
   and g_a1 (t_xb, x_n, bin);
   and g_a2 (t_yb, y, bin);
   or  g_o0 (t_or, t_xy, t_xb);
   or  g_o1 (bout, t_or, t_yb);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor with start/done handshake
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   serial_sub_if.slave bus
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] sh_res;
   logic [WIDTH-1:0] res_nxt;
   logic [CNT_W-1:0] cnt;
   logic             bor;
   logic             sa;
   logic             sb;
   logic             d;
   logic             bout;
   logic             last;

   // the single shared cell sees the current LSBs and the carried borrow
   fullsub_gate u_cell (
      .x    (sh_a[0]),
      .y    (sh_b[0]),
      .bin  (bor),
      .d    (d),
      .bout (bout)
   );

   assign last    = (cnt == CNT_W'(WIDTH - 1));
   assign res_nxt = {d, sh_res[WIDTH-1:1]};

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            bus.busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.busy  = 1'b1;
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // operand capture, per-bit shifting and result registration at completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a           <= '0;
         sh_b           <= '0;
         sh_res         <= '0;
         cnt            <= '0;
         bor            <= 1'b0;
         sa             <= 1'b0;
         sb             <= 1'b0;
         bus.diff       <= '0;
         bus.borrow_out <= 1'b0;
         bus.overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sh_a <= bus.a;
                  sh_b <= bus.b;
                  bor  <= 1'b0;
                  cnt  <= '0;
                  sa   <= bus.a[WIDTH-1];
                  sb   <= bus.b[WIDTH-1];
               end
            end
            SHIFT: begin
               sh_res <= res_nxt;
               sh_a   <= sh_a >> 1;
               sh_b   <= sh_b >> 1;
               bor    <= bout;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  bus.diff       <= res_nxt;
                  bus.borrow_out <= bout;
                  bus.overflow   <= (sa != sb) && (d != sa);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard bench for serial_sub
module tb_serial_sub;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t sb_q[$];

   serial_sub_if #(.WIDTH(W)) bus ();

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n) bus.done |=> !bus.done);
   a_done_busy  : assert property (@(posedge clk) disable iff (!rst_n) bus.done |-> bus.busy);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      e.diff   = x - y;
      e.borrow = (x < y);
      e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
      return e;
   endfunction

   // called at a negedge while idle; returns at the negedge of the first SHIFT cycle
   task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit push);
      bus.start = 1'b1;
      bus.a     = xa;
      bus.b     = xb;
      if (push) sb_q.push_back(model(xa, xb));
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_accept", bus.busy, 1);
   endtask

   // waits for done, checks latency and result, returns at the following idle negedge
   task automatic wait_done(input int cyc0);
      int   cyc;
      exp_t e;
      cyc = cyc0;
      while (!bus.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         check("busy_op", bus.busy, 1);
      end
      if (!bus.done) begin
         check("done_timeout", 0, 1);
      end else begin
         check("latency", cyc, W + 1);
         if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
         end else begin
            e = sb_q.pop_front();
            check("diff", bus.diff, e.diff);
            check("borrow_out", bus.borrow_out, e.borrow);
            check("overflow", bus.overflow, e.ovf);
         end
      end
      @(negedge clk);
      check("done_clear", bus.done, 0);
      check("busy_clear", bus.busy, 0);
   endtask

   initial begin
      bit saw_done;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_diff", bus.diff, 0);
      check("rst_borrow", bus.borrow_out, 0);
      check("rst_ovf", bus.overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases, back-to-back
      launch(8'h05, 8'h03, 1); wait_done(1);
      launch(8'h03, 8'h05, 1); wait_done(1);
      launch(8'h00, 8'h00, 1); wait_done(1);
      launch(8'h80, 8'h01, 1); wait_done(1);
      launch(8'h7F, 8'hFF, 1); wait_done(1);
      launch(8'h00, 8'hFF, 1); wait_done(1);
      launch(8'hFF, 8'h00, 1); wait_done(1);

      // busy interlock: start held high, operands disturbed mid-operation
      bus.start = 1'b1;
      bus.a     = 8'h10;
      bus.b     = 8'h01;
      sb_q.push_back(model(8'h10, 8'h01));
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      bus.a = 8'hAA;
      bus.b = 8'h55;
      wait_done(2);
      bus.a = 8'h33;
      bus.b = 8'h11;
      sb_q.push_back(model(8'h33, 8'h11));
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_reaccept", bus.busy, 1);
      wait_done(1);

      // reset during the 4th SHIFT cycle
      launch(8'h20, 8'h01, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_diff", bus.diff, 0);
      check("midrst_borrow", bus.borrow_out, 0);
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         saw_done = saw_done | bus.done;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         saw_done = saw_done | bus.done;
      end
      check("midrst_no_done", saw_done, 0);
      launch(8'h09, 8'h04, 1); wait_done(1);

      // randomised sweep
      for (int i = 0; i < 1000; i++) begin
         launch(W'($urandom), W'($urandom), 1);
         wait_done(1);
      end

      check("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
